// File: rtl/lzw_pkg.sv
// lzw_pkg: shared widths, dictionary entry layout and decoder FSM states for the LZW decode path
package lzw_pkg;
  localparam int CODE_WIDTH = 11;
  localparam int CHAR_WIDTH = 8;
  localparam int FIRST_CODE = 256;
  localparam int DICT_SIZE = (1 << CODE_WIDTH) - FIRST_CODE;
  typedef struct packed {
    logic [CODE_WIDTH-1:0] prefix;
    logic [CHAR_WIDTH-1:0] suffix;
  } dict_entry_t;
  typedef enum logic [1:0] {IDLE, WALK, EMIT} state_t;
endpackage

// File: rtl/lzw_char_stack.sv
// lzw_char_stack: MAX_LEN-deep byte LIFO; push/pop/flush in, din in, top/count/full/empty out
module lzw_char_stack import lzw_pkg::*; #(
  parameter int MAX_LEN = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           flush,
  input  logic [CHAR_WIDTH-1:0]          din,
  output logic [CHAR_WIDTH-1:0]          top,
  output logic [$clog2(MAX_LEN+1)-1:0]   count,
  output logic                           full,
  output logic                           empty
);
  localparam int AW = $clog2(MAX_LEN);
  localparam int CW = $clog2(MAX_LEN + 1);
  logic [CHAR_WIDTH-1:0] mem [MAX_LEN];
  assign top = mem[AW'(count - 1'b1)];
  assign full = count == CW'(MAX_LEN);
  assign empty = count == '0;
  always_ff @(posedge clk)
    if (push && !full) mem[AW'(count)] <= din;
  always_ff @(posedge clk or negedge rst)
    if (!rst) count <= '0;
    else count <= flush ? '0 : (push && !full) ? count + 1'b1 : (pop && !empty) ? count - 1'b1 : count;
endmodule

// File: rtl/lzw_decode_dict.sv
// lzw_decode_dict: LZW decoder dictionary + string unroller; ports: dict write (wr_*, next_code, dict_full, clr), code in (code_*), byte out (out_*), first_byte, err
module lzw_decode_dict import lzw_pkg::*; #(
  parameter int MAX_LEN = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [CODE_WIDTH-1:0] wr_prefix,
  input  logic [CHAR_WIDTH-1:0] wr_suffix,
  output logic [CODE_WIDTH:0]   next_code,
  output logic                  dict_full,
  input  logic                  code_valid,
  input  logic [CODE_WIDTH-1:0] code_in,
  output logic                  code_ready,
  output logic                  out_valid,
  output logic [CHAR_WIDTH-1:0] out_byte,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [CHAR_WIDTH-1:0] first_byte,
  output logic                  err
);
  localparam int CNT_W = $clog2(MAX_LEN + 1);
  state_t state;
  logic [CODE_WIDTH-1:0] cur;
  dict_entry_t dict [DICT_SIZE];
  dict_entry_t ent;
  logic [CNT_W-1:0] cnt;
  logic [CHAR_WIDTH-1:0] top, push_byte;
  logic we, accept, undef, lit, push, pop, ovf, st_full, st_empty;
  assign dict_full = next_code[CODE_WIDTH];
  assign we = wr_en && !dict_full && !clr;
  assign accept = code_valid && code_ready && !clr;
  assign undef = {1'b0, code_in} >= next_code;
  assign ent = dict[cur - CODE_WIDTH'(FIRST_CODE)];
  assign lit = cur < CODE_WIDTH'(FIRST_CODE);
  assign ovf = state == WALK && st_full && !clr;
  assign push = state == WALK && !st_full && !clr;
  assign push_byte = lit ? cur[CHAR_WIDTH-1:0] : ent.suffix;
  assign code_ready = state == IDLE;
  assign out_valid = state == EMIT;
  assign out_byte = out_valid ? top : '0;
  assign out_last = out_valid && cnt == CNT_W'(1);
  assign pop = out_valid && out_ready && !st_empty && !clr;
  lzw_char_stack #(.MAX_LEN(MAX_LEN)) u_stack (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(clr || ovf), .din(push_byte),
    .top(top), .count(cnt), .full(st_full), .empty(st_empty)
  );
  always_ff @(posedge clk)
    if (we) dict[next_code[CODE_WIDTH-1:0] - CODE_WIDTH'(FIRST_CODE)] <= '{wr_prefix, wr_suffix};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cur <= '0;
      next_code <= (CODE_WIDTH+1)'(FIRST_CODE);
      first_byte <= '0;
      err <= 1'b0;
    end else begin
      err <= (accept && undef) || ovf;
      if (clr) begin
        next_code <= (CODE_WIDTH+1)'(FIRST_CODE);
        state <= IDLE;
      end else begin
        if (we) next_code <= next_code + 1'b1;
        if (accept) begin
          cur <= code_in;
          state <= undef ? IDLE : WALK;
        end
        if (state == WALK) begin
          if (st_full) state <= IDLE;
          else if (lit) begin
            first_byte <= cur[CHAR_WIDTH-1:0];
            state <= EMIT;
          end else cur <= ent.prefix;
        end
        if (pop && cnt == CNT_W'(1)) state <= IDLE;
      end
    end
endmodule

// File: tb/tb_lzw_decode_dict.sv
// tb_lzw_decode_dict: directed self-checking bench for lzw_decode_dict
module tb_lzw_decode_dict;
  logic clk = 0, rst = 0, clr = 0, wr_en = 0, code_valid = 0, out_ready = 0;
  logic [10:0] wr_prefix = '0, code_in = '0;
  logic [7:0] wr_suffix = '0;
  logic [11:0] next_code;
  logic dict_full, code_ready, out_valid, out_last, err;
  logic [7:0] out_byte, first_byte;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  lzw_decode_dict dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_prefix(wr_prefix), .wr_suffix(wr_suffix),
    .next_code(next_code), .dict_full(dict_full), .code_valid(code_valid), .code_in(code_in),
    .code_ready(code_ready), .out_valid(out_valid), .out_byte(out_byte), .out_last(out_last),
    .out_ready(out_ready), .first_byte(first_byte), .err(err)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic write_entry(input logic [10:0] p, input logic [7:0] s);
    wr_en = 1; wr_prefix = p; wr_suffix = s;
    tick();
    wr_en = 0;
  endtask
  task automatic send_code(input logic [10:0] c);
    code_valid = 1; code_in = c;
    tick();
    code_valid = 0;
  endtask
  task automatic test_reset;
    rst = 0;
    repeat (3) tick();
    checks++;
    if ({code_ready, out_valid, err} !== 3'b100) begin
      errors++; $display("FAIL reset_hold: ready/valid/err=%b required 100", {code_ready, out_valid, err});
    end
    rst = 1;
    tick();
    checks++;
    if (next_code !== 12'd256 || dict_full !== 1'b0) begin
      errors++; $display("FAIL reset_next_code: next_code=%0d full=%b required 256 0", next_code, dict_full);
    end
    checks++;
    if ({out_byte, out_last, first_byte, err, code_ready} !== {8'h00, 1'b0, 8'h00, 1'b0, 1'b1}) begin
      errors++; $display("FAIL reset_outputs: out_byte=%h last=%b first=%h err=%b ready=%b required 00 0 00 0 1", out_byte, out_last, first_byte, err, code_ready);
    end
  endtask
  task automatic test_literal;
    logic [7:0] lits [2] = '{8'h41, 8'hFF};
    out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      send_code({3'b000, lits[i]});
      checks++;
      if (out_valid !== 1'b0 || code_ready !== 1'b0) begin
        errors++; $display("FAIL literal_walk: valid=%b ready=%b required 0 0", out_valid, code_ready);
      end
      tick();
      checks++;
      if ({out_valid, out_byte, out_last, first_byte} !== {1'b1, lits[i], 1'b1, lits[i]}) begin
        errors++; $display("FAIL literal_emit: valid=%b byte=%h last=%b first=%h required 1 %h 1 %h", out_valid, out_byte, out_last, first_byte, lits[i], lits[i]);
      end
      tick();
      checks++;
      if (code_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++; $display("FAIL literal_done: ready=%b valid=%b required 1 0", code_ready, out_valid);
      end
    end
  endtask
  task automatic test_chain;
    logic [7:0] exp [3] = '{8'h41, 8'h42, 8'h43};
    write_entry(11'h041, 8'h42);
    write_entry(11'd256, 8'h43);
    checks++;
    if (next_code !== 12'd258) begin
      errors++; $display("FAIL chain_next_code: got %0d required 258", next_code);
    end
    out_ready = 1;
    send_code(11'd257);
    for (int c = 1; c <= 2; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL chain_latency: out_valid=%b at cycle %0d required 0", out_valid, c);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({out_valid, out_byte, out_last} !== {1'b1, exp[i], i == 2}) begin
        errors++; $display("FAIL chain_byte%0d: valid=%b byte=%h last=%b required 1 %h %b", i, out_valid, out_byte, out_last, exp[i], i == 2);
      end
    end
    checks++;
    if (first_byte !== 8'h41) begin
      errors++; $display("FAIL chain_first_byte: got %h required 41", first_byte);
    end
    tick();
    checks++;
    if (code_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL chain_done: ready=%b valid=%b required 1 0", code_ready, out_valid);
    end
  endtask
  task automatic test_backpressure;
    int n;
    out_ready = 0;
    send_code(11'd257);
    for (n = 0; n < 10 && !out_valid; n++) tick();
    checks++;
    if ({out_valid, out_byte, out_last} !== {1'b1, 8'h41, 1'b0}) begin
      errors++; $display("FAIL bp_first: valid=%b byte=%h last=%b required 1 41 0", out_valid, out_byte, out_last);
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if ({out_valid, out_byte, out_last} !== {1'b1, 8'h42, 1'b0}) begin
        errors++; $display("FAIL bp_hold%0d: valid=%b byte=%h last=%b required 1 42 0", c, out_valid, out_byte, out_last);
      end
      if (c < 5) tick();
    end
    out_ready = 1;
    tick();
    checks++;
    if ({out_valid, out_byte, out_last} !== {1'b1, 8'h43, 1'b1}) begin
      errors++; $display("FAIL bp_last: valid=%b byte=%h last=%b required 1 43 1", out_valid, out_byte, out_last);
    end
    tick();
    checks++;
    if (code_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_done: ready=%b valid=%b required 1 0", code_ready, out_valid);
    end
  endtask
  task automatic test_undefined;
    send_code(11'd300);
    checks++;
    if ({err, out_valid, code_ready} !== 3'b101) begin
      errors++; $display("FAIL undef_300: err/valid/ready=%b required 101", {err, out_valid, code_ready});
    end
    tick();
    checks++;
    if ({err, out_valid, code_ready} !== 3'b001) begin
      errors++; $display("FAIL undef_pulse: err/valid/ready=%b required 001", {err, out_valid, code_ready});
    end
    code_valid = 1; code_in = 11'd258;
    wr_en = 1; wr_prefix = 11'h041; wr_suffix = 8'h44;
    tick();
    code_valid = 0; wr_en = 0;
    checks++;
    if (err !== 1'b1 || next_code !== 12'd259) begin
      errors++; $display("FAIL undef_same_cycle: err=%b next_code=%0d required 1 259", err, next_code);
    end
    tick();
    checks++;
    if ({err, out_valid, code_ready} !== 3'b001) begin
      errors++; $display("FAIL undef_same_after: err/valid/ready=%b required 001", {err, out_valid, code_ready});
    end
  endtask
  task automatic test_full_clear;
    int errs, err_at, vcount, n;
    logic [7:0] exp;
    clr = 1;
    tick();
    clr = 0;
    checks++;
    if (next_code !== 12'd256) begin
      errors++; $display("FAIL clr_initial: next_code=%0d required 256", next_code);
    end
    wr_en = 1; wr_prefix = 11'h041;
    for (int i = 0; i < 1792; i++) begin
      wr_suffix = 8'(i);
      tick();
    end
    checks++;
    if (next_code !== 12'd2048 || dict_full !== 1'b1) begin
      errors++; $display("FAIL full: next_code=%0d full=%b required 2048 1", next_code, dict_full);
    end
    tick();
    checks++;
    if (next_code !== 12'd2048 || err !== 1'b0) begin
      errors++; $display("FAIL full_ignore: next_code=%0d err=%b required 2048 0", next_code, err);
    end
    clr = 1;
    tick();
    clr = 0; wr_en = 0;
    checks++;
    if (next_code !== 12'd256 || dict_full !== 1'b0) begin
      errors++; $display("FAIL clr_full: next_code=%0d full=%b required 256 0", next_code, dict_full);
    end
    write_entry(11'h033, 8'h00);
    for (int i = 1; i < 64; i++) write_entry(11'(255 + i), 8'(i));
    checks++;
    if (next_code !== 12'd320) begin
      errors++; $display("FAIL deep_next_code: got %0d required 320", next_code);
    end
    out_ready = 1;
    send_code(11'd319);
    errs = 0; err_at = 0; vcount = 0;
    for (int c = 1; c <= 80; c++) begin
      tick();
      if (err) begin errs++; err_at = c; end
      if (out_valid) vcount++;
    end
    checks++;
    if (errs !== 1 || err_at !== 65 || vcount !== 0) begin
      errors++; $display("FAIL overflow: err_pulses=%0d at=%0d valid_cycles=%0d required 1 65 0", errs, err_at, vcount);
    end
    checks++;
    if (code_ready !== 1'b1 || first_byte !== 8'h41) begin
      errors++; $display("FAIL overflow_state: ready=%b first=%h required 1 41", code_ready, first_byte);
    end
    send_code(11'd318);
    for (n = 0; n < 80 && !out_valid; n++) tick();
    for (int j = 0; j < 64; j++) begin
      exp = (j == 0) ? 8'h33 : 8'(j - 1);
      checks++;
      if ({out_valid, out_byte, out_last} !== {1'b1, exp, j == 63}) begin
        errors++; $display("FAIL depth64_byte%0d: valid=%b byte=%h last=%b required 1 %h %b", j, out_valid, out_byte, out_last, exp, j == 63);
      end
      tick();
    end
    checks++;
    if (code_ready !== 1'b1 || out_valid !== 1'b0 || first_byte !== 8'h33) begin
      errors++; $display("FAIL depth64_done: ready=%b valid=%b first=%h required 1 0 33", code_ready, out_valid, first_byte);
    end
  endtask
  initial begin
    test_reset();
    test_literal();
    test_chain();
    test_backpressure();
    test_undefined();
    test_full_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lzw_decode_dict.md
# lzw_decode_dict

Decoder-side LZW dictionary and string unroller. It is the read-back counterpart of the encoder's hash/conflict-table lookup: it stores (prefix code, suffix byte) entries as the decoder learns them. It walks a received code's prefix chain into a LIFO and streams the recovered bytes out in forward order over a valid/ready handshake. It sits between the code deserializer and the output byte FIFO in the decompression path.

## Interface
- CODE_WIDTH, 11, code width; dictionary holds codes FIRST_CODE..2^CODE_WIDTH-1
- CHAR_WIDTH, 8, byte width; codes below 2^CHAR_WIDTH are implicit literals
- MAX_LEN, 64, maximum string length (stack depth)

- clk  in  1  single clock, all logic on posedge
- rst  in  1  reset; asynchronous, active-low
- clr  in  1  synchronous dictionary clear
- wr_en  in  1  append entry at next_code
- wr_prefix  in  CODE_WIDTH  prefix code of new entry
- wr_suffix  in  CHAR_WIDTH  suffix byte of new entry
- next_code  out  CODE_WIDTH+1  next free code
- dict_full  out  1  next_code == 2^CODE_WIDTH
- code_valid  in  1  code_in offered
- code_in  in  CODE_WIDTH  code to decode
- code_ready  out  1  block idle, accepts code
- out_valid  out  1  out_byte valid
- out_byte  out  CHAR_WIDTH  recovered byte
- out_last  out  1  final byte of current string
- out_ready  in  1  downstream accepts byte
- first_byte  out  CHAR_WIDTH  first byte of last fully decoded string (used upstream for KwKwK)
- err  out  1  one-cycle pulse: undefined code or stack overflow

## Operation
- Dictionary: register array, 2^CODE_WIDTH-256 entries of {prefix, suffix}, combinational read. Write on wr_en && !dict_full: entry[next_code] <= {wr_prefix, wr_suffix}, next_code++. Writes while full are ignored, with no err. Writes are legal in any state.
- FSM states:
  - IDLE: code_ready=1. Accept on code_valid && code_ready; cur <= code_in.
    - If code_in >= next_code (sampled before a same-cycle write): pulse err, stay IDLE.
    - Otherwise go to WALK.
  - WALK: one push per cycle.
    - If cur < 256: push cur[7:0], latch first_byte <= cur[7:0], go to EMIT.
    - Otherwise: push entry[cur].suffix, cur <= entry[cur].prefix.
    - If a push would exceed MAX_LEN: pulse err, flush the stack, go to IDLE. first_byte is unchanged.
  - EMIT: out_valid=1, out_byte=stack top, out_last=(count==1). Pop on out_valid && out_ready. After the last pop, go to IDLE.
- Output hold: out_byte and out_last stay stable while out_valid && !out_ready.
- clr: next_code <= 256, stack flushed, FSM to IDLE, out_valid drops the next cycle. clr has priority over a same-cycle wr_en and over a code accept.

## Timing
- Reset values: code_ready=1, out_valid=0, out_byte=0, out_last=0, first_byte=0, err=0, next_code=256, dict_full=0, stack empty.
- Reset mid-operation aborts immediately, with no partial output. Dictionary contents are don't-care after reset.
- For a string of length L accepted at edge E0:
  - WALK pushes at E1..EL.
  - First out_valid is in the cycle after EL.
  - L handshakes are needed minimum, L cycles at full throughput.
  - code_ready rises the cycle after the last byte's handshake.
- A literal has L=1: out_valid in the cycle after E1.
- err is asserted for exactly one cycle after the offending edge.
- next_code and dict_full update one cycle after the write edge.

## Structure
- Shared package lzw_pkg: CODE_WIDTH, CHAR_WIDTH, FIRST_CODE=256, dict entry struct {prefix, suffix}, FSM state enum (IDLE, WALK, EMIT).
- Sub-module lzw_char_stack: MAX_LEN x CHAR_WIDTH LIFO.
  - Inputs: push, pop, flush.
  - Outputs: top, count, full, empty.
  - Push and pop never occur in the same cycle.

## Test plan
- Reset: hold rst=0, then release → code_ready=1, out_valid=0, next_code=256, dict_full=0, err=0.
- Literal: code_in=0x41 → one byte 0x41 with out_last=1 in the cycle after E1; first_byte=0x41; code_ready returns.
- Chain: write (0x41,0x42)→256 and (256,0x43)→257, then code 257 → bytes 41, 42, 43 on consecutive cycles with out_ready=1; out_last only on 43; first out_valid 3 cycles after accept; first_byte=0x41.
- Backpressure: same chain with out_ready low for 5 cycles while 0x42 is presented → 0x42 held stable, no loss or duplication, then 0x43 with out_last=1.
- Undefined code: code 300 accepted with next_code=258 → single err pulse, no out_valid, code_ready=1 the next cycle. Also: code 258 accepted in the same cycle as a write to 258 → err.
- Full/clear: 1792 writes → next_code=2048, dict_full=1; a further write is ignored. clr → next_code=256, dict_full=0. A chain of depth 65 → err, stack flushed, no output.
